// File: rtl/i2c_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_target                                                   |
// | Description : I2C target (responder). Oversamples SCL/SDA on clk, detects   |
// |               START/STOP, matches a 7-bit address and exposes a register   |
// |               pointer with auto-increment on a simple register bus.        |
// | Ports       : clk, reset       - system clock, sync active-high reset      |
// |               scl_in, sda_in   - raw pad levels                             |
// |               sda_oe           - 1 pulls SDA low (open-drain)               |
// |               reg_addr/wdata/wr_en/rdata - register bus                     |
// |               busy, stop_seen  - transaction status                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int         PTR_W    = 8,
  parameter int         FILT     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_wr_en,
  input  logic [7:0]       reg_rdata,
  output logic             busy,
  output logic             stop_seen
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK, S_RX_PTR, S_RX_DATA, S_TX_DATA, S_M_ACK, S_IGNORE
  } state_t;

  // input conditioning
  logic            scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic [FILT-1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic            scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic            scl_prev_q, sda_prev_q;
  logic            scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

  // protocol state
  state_t          state_q, state_d, ack_to_q, ack_to_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      sh_q, sh_d, byte_in;
  logic            oe_q, oe_d, wr_q, wr_d, busy_q, busy_d, stop_q, stop_d;
  logic            ack_ph_q, ack_ph_d, mack_q, mack_d, load;
  logic [PTR_W-1:0] addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;

  always_comb begin
    scl_hist_d = {scl_hist_q[FILT-2:0], scl_s2_q};
    sda_hist_d = {sda_hist_q[FILT-2:0], sda_s2_q};
    // a level is accepted only once FILT consecutive samples agree
    scl_f_d = (&scl_hist_q) ? 1'b1 : ((~|scl_hist_q) ? 1'b0 : scl_f_q);
    sda_f_d = (&sda_hist_q) ? 1'b1 : ((~|sda_hist_q) ? 1'b0 : sda_f_q);
  end

  assign scl_rise  =  scl_f_q & ~scl_prev_q;
  assign scl_fall  = ~scl_f_q &  scl_prev_q;
  assign sda_rise  =  sda_f_q & ~sda_prev_q;
  assign sda_fall  = ~sda_f_q &  sda_prev_q;
  assign start_det = sda_fall & scl_f_q;
  assign stop_det  = sda_rise & scl_f_q;
  assign byte_in   = {sh_q[6:0], sda_f_q};

  always_comb begin
    state_d  = state_q;
    ack_to_d = ack_to_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    oe_d     = oe_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = 1'b0;
    busy_d   = busy_q;
    stop_d   = 1'b0;
    ack_ph_d = ack_ph_q;
    mack_d   = mack_q;
    load     = 1'b0;

    // pointer advances the cycle after each write strobe
    if (wr_q) addr_d = addr_q + PTR_W'(1);

    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
    end else if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_RX_PTR, S_RX_DATA: begin
          if (scl_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d    = 4'd0;
              ack_ph_d = 1'b0;
              state_d  = S_ACK;
              if (state_q == S_ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  busy_d   = 1'b1;
                  ack_to_d = byte_in[0] ? S_TX_DATA : S_RX_PTR;
                end else begin
                  busy_d  = 1'b0;
                  state_d = S_IGNORE;
                end
              end else if (state_q == S_RX_PTR) begin
                addr_d   = PTR_W'(byte_in);
                ack_to_d = S_RX_DATA;
              end else begin
                wdata_d  = byte_in;
                wr_d     = 1'b1;
                ack_to_d = S_RX_DATA;
              end
            end
          end
        end
        S_ACK: begin
          // first fall after the 8th bit pulls SDA, the next one releases it
          if (scl_fall) begin
            if (!ack_ph_q) begin
              oe_d     = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              oe_d     = 1'b0;
              ack_ph_d = 1'b0;
              cnt_d    = 4'd0;
              if (ack_to_q == S_TX_DATA) load = 1'b1;
              else                       state_d = ack_to_q;
            end
          end
        end
        S_TX_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              mack_d  = 1'b0;
              state_d = S_M_ACK;
            end else begin
              oe_d  = ~sh_q[7];
              sh_d  = {sh_q[6:0], 1'b0};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        S_M_ACK: begin
          if (scl_rise) begin
            if (sda_f_q) begin
              busy_d  = 1'b0;
              state_d = S_IGNORE;
            end else begin
              mack_d = 1'b1;
            end
          end else if (scl_fall && mack_q) begin
            load = 1'b1;
          end
        end
        default: ;
      endcase

      // latch a read byte and drive its MSB at the same fall
      if (load) begin
        sh_d    = {reg_rdata[6:0], 1'b0};
        oe_d    = ~reg_rdata[7];
        cnt_d   = 4'd1;
        addr_d  = addr_q + PTR_W'(1);
        state_d = S_TX_DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      ack_to_q   <= S_IDLE;
      cnt_q      <= 4'd0;
      sh_q       <= 8'd0;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      stop_q     <= 1'b0;
      ack_ph_q   <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      scl_s1_q   <= scl_in;
      scl_s2_q   <= scl_s1_q;
      sda_s1_q   <= sda_in;
      sda_s2_q   <= sda_s1_q;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
      state_q    <= state_d;
      ack_to_q   <= ack_to_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      oe_q       <= oe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      stop_q     <= stop_d;
      ack_ph_q   <= ack_ph_d;
      mack_q     <= mack_d;
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_q;
  assign busy      = busy_q;
  assign stop_seen = stop_q;

endmodule
`default_nettype wire
